axil_macc_scheduler: RTL and testbench

Job scheduler that sequences the HLS-generated `axil_macc` core through its `ap_ctrl_hs` handshake. It buffers operand pairs from one upstream requester, launches one core transaction per job, and returns each result (or a timeout error) on a valid/ready output. It sits between the testbench/system driver and the core, in the same clock domain, and owns every `ap_start` edge the core sees.

---
 rtl/axil_macc_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_axil_macc_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_macc_scheduler.sv
// Job scheduler for the axil_macc core: queues operand pairs, drives one ap_ctrl_hs
// transaction per job and returns each result (or a timeout error) on a valid/ready port.
module axil_macc_scheduler #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              core_ap_start,
    input  logic              core_ap_ready,
    input  logic              core_ap_done,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_timeout,
    output logic [15:0]       job_count,
    output logic              err_sticky,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [2*DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [TMR_W-1:0]      timer_r;
    logic                  start_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_data_r;
    logic                  out_timeout_r;
    logic [15:0]           job_count_r;
    logic                  err_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  tmo_s;
    logic                  cap_result_s;
    logic                  cap_timeout_s;
    logic                  accept_s;

    assign in_ready      = (count_r != CNT_W'(FIFO_DEPTH));
    assign busy          = (state_r != ST_IDLE) || (count_r != {CNT_W{1'b0}});
    assign push_s        = in_valid && in_ready;
    assign tmo_s         = (timer_r == TMR_W'(TIMEOUT - 1));
    assign core_ap_start = start_r;
    assign core_a        = a_r;
    assign core_b        = b_r;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_timeout   = out_timeout_r;
    assign job_count     = job_count_r;
    assign err_sticky    = err_r;

    // Next-state decode; a done in the timeout cycle wins over the abort.
    always_comb begin
        next_state_s  = state_r;
        pop_s         = 1'b0;
        cap_result_s  = 1'b0;
        cap_timeout_s = 1'b0;
        accept_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_LAUNCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (core_ap_ready && core_ap_done) begin
                    cap_result_s = 1'b1;
                    next_state_s = ST_RESP;
                end else if (tmo_s) begin
                    cap_timeout_s = 1'b1;
                    next_state_s  = ST_RESP;
                end else if (core_ap_ready) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_LAUNCH;
                end
            end
            ST_WAIT: begin
                if (core_ap_done) begin
                    cap_result_s = 1'b1;
                    next_state_s = ST_RESP;
                end else if (tmo_s) begin
                    cap_timeout_s = 1'b1;
                    next_state_s  = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Queue storage; contents are don't-care until written, pointers carry validity.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_a, in_b};
        end
    end

    // State, queue pointers, timer and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            timer_r       <= {TMR_W{1'b0}};
            start_r       <= 1'b0;
            a_r           <= {DATA_W{1'b0}};
            b_r           <= {DATA_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_data_r    <= {DATA_W{1'b0}};
            out_timeout_r <= 1'b0;
            job_count_r   <= 16'd0;
            err_r         <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            start_r     <= (next_state_s == ST_LAUNCH);
            out_valid_r <= (next_state_s == ST_RESP);

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                a_r      <= mem_r[rd_ptr_r][2*DATA_W-1:DATA_W];
                b_r      <= mem_r[rd_ptr_r][DATA_W-1:0];
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end

            if (pop_s) begin
                timer_r <= {TMR_W{1'b0}};
            end else if ((state_r == ST_LAUNCH) || (state_r == ST_WAIT)) begin
                timer_r <= timer_r + TMR_W'(1);
            end

            if (cap_result_s) begin
                out_data_r    <= core_result;
                out_timeout_r <= 1'b0;
            end else if (cap_timeout_s) begin
                out_data_r    <= {DATA_W{1'b0}};
                out_timeout_r <= 1'b1;
                err_r         <= 1'b1;
            end

            if (accept_s) begin
                job_count_r <= job_count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axil_macc_scheduler.sv
// Self-checking bench for axil_macc_scheduler: table of single-job vectors plus
// burst, back-pressure and mid-operation reset sequences, all scored against a queue.
module tb_axil_macc_scheduler;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = 32'd0;
    logic [DW-1:0] in_b = 32'd0;
    logic          core_ap_start;
    logic          core_ap_ready = 1'b0;
    logic          core_ap_done = 1'b0;
    logic [DW-1:0] core_a;
    logic [DW-1:0] core_b;
    logic [DW-1:0] core_result = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_timeout;
    logic [15:0]   job_count;
    logic          err_sticky;
    logic          busy;

    always #5 clock = ~clock;

    axil_macc_scheduler #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done), .core_a(core_a), .core_b(core_b),
        .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_timeout(out_timeout), .job_count(job_count),
        .err_sticky(err_sticky), .busy(busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          hang;
        bit          ovr_en;
        logic [31:0] ovr;
        logic [31:0] exp_data;
        bit          exp_tmo;
        int          exp_vcyc;
        bit          exp_err;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_jobs = 0;

    // core model knobs
    int          done_lat = 1;
    bit          hang = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr = 32'd0;
    bit          force_done = 1'b0;
    int          cyc = 0;
    bit          prev_start = 1'b0;
    bit          done_sent = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ap_start"}, {31'd0, core_ap_start}, 32'd0);
        chk({tag, "_core_a"}, core_a, 32'd0);
        chk({tag, "_core_b"}, core_b, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_timeout"}, {31'd0, out_timeout}, 32'd0);
        chk({tag, "_job_count"}, {16'd0, job_count}, 32'd0);
        chk({tag, "_err_sticky"}, {31'd0, err_sticky}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Behavioural ap_ctrl_hs core: ap_ready in the first start cycle, ap_done at cycle done_lat.
    always @(negedge clock) begin
        if (core_ap_start && !prev_start) begin
            cyc       = 1;
            done_sent = 1'b0;
        end else begin
            cyc = cyc + 1;
        end
        prev_start    = core_ap_start;
        core_ap_ready = core_ap_start && (cyc == 1);
        core_ap_done  = force_done || (!hang && !done_sent && (cyc == done_lat));
        if (core_ap_done) begin
            done_sent   = 1'b1;
            core_result = ovr_en ? ovr : core_a * core_b;
        end else begin
            core_result = $urandom;
        end
    end

    // Scoreboard: each accepted response is compared with the oldest expectation.
    always @(negedge clock) begin
        #1;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: got %0h expected none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", out_data, mon_e.data);
                chk("sb_timeout", {31'd0, out_timeout}, {31'd0, mon_e.tmo});
                chk("sb_job_count", {16'd0, job_count}, exp_jobs);
                exp_jobs++;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int c;
        done_lat = v.lat; hang = v.hang; ovr_en = v.ovr_en; ovr = v.ovr; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b1; in_a = v.a; in_b = v.b;
        chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back('{v.exp_data, v.exp_tmo});
        @(negedge clock);
        in_valid = 1'b0;
        chk("vec_idle_gap_start", {31'd0, core_ap_start}, 32'd0);
        @(negedge clock);
        chk("vec_launch_start", {31'd0, core_ap_start}, 32'd1);
        chk("vec_core_a", core_a, v.a);
        chk("vec_core_b", core_b, v.b);
        c = 1;
        while (!out_valid && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk("vec_valid_cycle", c, v.exp_vcyc);
        chk("vec_err_sticky", {31'd0, err_sticky}, {31'd0, v.exp_err});
        @(negedge clock);
        chk("vec_busy_after", {31'd0, busy}, 32'd0);
        chk("vec_job_count", {16'd0, job_count}, exp_jobs);
    endtask

    initial begin
        vec_t vecs[8];
        int   c;
        int   bad;
        logic [31:0] prod;

        vecs[0] = '{32'd3,         32'd5,   4,  1'b0, 1'b0, 32'd0,      32'd15,         1'b0, 5,  1'b0};
        vecs[1] = '{32'd7,         32'd6,   1,  1'b0, 1'b0, 32'd0,      32'd42,         1'b0, 2,  1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'd2,   2,  1'b0, 1'b0, 32'd0,      32'hFFFF_FFFE,  1'b0, 3,  1'b0};
        vecs[3] = '{32'd100,       32'd0,   3,  1'b0, 1'b0, 32'd0,      32'd0,          1'b0, 4,  1'b0};
        vecs[4] = '{32'd9,         32'd9,   16, 1'b0, 1'b0, 32'd0,      32'd81,         1'b0, 17, 1'b0};
        vecs[5] = '{32'd20,        32'd30,  1,  1'b1, 1'b0, 32'd0,      32'd0,          1'b1, 17, 1'b1};
        vecs[6] = '{32'd2,         32'd3,   2,  1'b0, 1'b0, 32'd0,      32'd6,          1'b0, 3,  1'b1};
        vecs[7] = '{32'd1,         32'd1,   1,  1'b0, 1'b1, 32'hDEAD,   32'hDEAD,       1'b0, 2,  1'b1};

        repeat (3) @(negedge clock);
        chk_reset_values("por");
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Burst of five jobs against a slow core: four wait in the queue behind the in-flight one.
        hang = 1'b0; ovr_en = 1'b0; done_lat = 8; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_a = i + 10; in_b = i + 1;
            chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
            prod = (i + 10) * (i + 1);
            exp_q.push_back('{prod, 1'b0});
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("burst_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("burst_busy", {31'd0, busy}, 32'd1);
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clock);
            c++;
        end
        chk("burst_drain", exp_q.size(), 32'd0);
        @(negedge clock);
        chk("burst_idle", {31'd0, busy}, 32'd0);

        // Downstream stall: response must hold and no second launch may start.
        done_lat = 2; out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h10;
        exp_q.push_back('{32'h12340, 1'b0});
        @(negedge clock);
        in_a = 32'd4; in_b = 32'd4;
        exp_q.push_back('{32'd16, 1'b0});
        @(negedge clock);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("stall_valid_seen", {31'd0, out_valid}, 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_data !== 32'h12340 || core_ap_start !== 1'b0 || out_valid !== 1'b1 ||
                core_a !== 32'h1234) bad++;
        end
        chk("stall_stable_cycles", bad, 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("stall_drain", exp_q.size(), 32'd0);

        // Reset while waiting on the core with two jobs queued.
        done_lat = 30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_a = i + 1; in_b = i + 1;
        end
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        chk("rst_pre_start", {31'd0, core_ap_start}, 32'd0);
        reset = 1'b0;
        exp_jobs = 0;
        @(negedge clock);
        chk_reset_values("mid");
        reset = 1'b1;
        @(posedge clock);
        force_done = 1'b1;
        @(posedge clock);
        force_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0 || core_ap_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rst_late_done_ignored", bad, 32'd0);
        chk("rst_job_count", {16'd0, job_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
